efuse_prog_seq: RTL

- Write-side engine behind the efuse read/write controller.
- Accepts a write_start pulse, slice select and NW-bit data word from the controller. Sequences the per-bit program pulses into the 256-bit efuse macro.
- Reports efuse_busy_write while active and a one-cycle write_done pulse on completion.
- Bits are programmed LSB first. Only '1' bits are strobed; '0' bits are skipped.

---
 rtl/efuse_prog_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/efuse_prog_seq.sv
`default_nettype none
// efuse_prog_seq: write-side program sequencer for a 256-bit efuse macro.
// Walks the latched word LSB first and strobes only '1' bits, with setup, program, hold and recovery timing.
module efuse_prog_seq #(
  parameter int NW    = 64,
  parameter int T_SU  = 4,
  parameter int T_PGM = 100,
  parameter int T_HD  = 4,
  parameter int T_REC = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_start,
  input  logic [$clog2(256/NW)-1:0] efuse_write_sel,
  input  logic [NW-1:0]             write_data,
  output logic                      write_done,
  output logic                      efuse_busy_write,
  output logic [7:0]                efuse_a,
  output logic                      efuse_pgenb,
  output logic                      efuse_strobe,
  output logic [$clog2(NW+1)-1:0]   prog_cnt
);

  localparam int IW   = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW   = $clog2(NW + 1);
  localparam int TM1  = (T_SU > T_PGM) ? T_SU : T_PGM;
  localparam int TM2  = (T_HD > T_REC) ? T_HD : T_REC;
  localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCAN   = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4,
    RECOV  = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [NW-1:0]   data;
  logic [7:0]      base;
  logic            cnt_inc;
  logic            load_addr;
  logic            last_bit;

  assign last_bit = (idx == IW'(NW - 1));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    timer_nxt = timer;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (write_start) begin
          state_nxt = SETUP;
          idx_nxt   = '0;
          timer_nxt = TW'(T_SU - 1);
        end
      end
      SETUP: begin
        if (timer == '0) state_nxt = SCAN;
        else             timer_nxt = timer - TW'(1);
      end
      SCAN: begin
        if (data[idx]) begin
          state_nxt = STROBE;
          timer_nxt = TW'(T_PGM - 1);
          cnt_inc   = 1'b1;
        end else if (last_bit) begin
          state_nxt = RECOV;
          timer_nxt = TW'(T_REC - 1);
        end else begin
          idx_nxt = idx + IW'(1);
        end
      end
      STROBE: begin
        if (timer == '0) begin
          state_nxt = HOLD;
          timer_nxt = TW'(T_HD - 1);
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      HOLD: begin
        if (timer != '0) begin
          timer_nxt = timer - TW'(1);
        end else if (last_bit) begin
          state_nxt = RECOV;
          timer_nxt = TW'(T_REC - 1);
        end else begin
          state_nxt = SCAN;
          idx_nxt   = idx + IW'(1);
        end
      end
      RECOV: begin
        if (timer == '0) state_nxt = DONE;
        else             timer_nxt = timer - TW'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Address is presented at the start of the SCAN cycle so it leads the strobe by a full cycle.
    load_addr = (state_nxt == SCAN) && data[idx_nxt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      timer            <= '0;
      data             <= '0;
      base             <= '0;
      efuse_a          <= '0;
      efuse_pgenb      <= 1'b1;
      efuse_strobe     <= 1'b0;
      efuse_busy_write <= 1'b0;
      write_done       <= 1'b0;
      prog_cnt         <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      timer <= timer_nxt;
      if (state == IDLE && write_start) begin
        data     <= write_data;
        base     <= 8'(efuse_write_sel) * 8'(NW);
        prog_cnt <= '0;
      end else if (cnt_inc) begin
        prog_cnt <= prog_cnt + CW'(1);
      end
      if (load_addr) efuse_a <= base + 8'(idx_nxt);
      efuse_pgenb      <= !(state_nxt inside {SETUP, SCAN, STROBE, HOLD});
      efuse_strobe     <= (state_nxt == STROBE);
      efuse_busy_write <= (state_nxt != IDLE);
      write_done       <= (state_nxt == DONE);
    end
  end

endmodule
`default_nettype wire
